mac_operand_fifo: RTL
=====================

// Module: mac_operand_fifo
// PURPOSE
//  Parametrised operand staging queue in front of the MAC datapath. Captures
//  {second_operand, first_operand} pairs, plus an accumulator-clear tag, under a
//  valid/ready handshake. Holds up to DEPTH pairs and presents the oldest pair to
//  the MAC in first-word-fall-through order. Decouples operand fetch from MAC issue stalls.
// PARAMETERS
//  OP_W   32  width of each operand; mor_out is 2*OP_W
//  DEPTH  4   queue entries; power of two, >= 2
// PORTS
//  clock           in   1                 rising-edge clock
//  reset           in   1                 asynchronous, active-high; clears queue state
//  flush           in   1                 synchronous discard of all entries
//  in_valid        in   1                 producer has an operand pair
//  in_ready        out  1                 queue can accept (= !full)
//  first_operand   in   OP_W              low half of pushed pair
//  second_operand  in   OP_W              high half of pushed pair
//  in_acc_clr      in   1                 pair starts a new accumulation
//  out_valid       out  1                 head entry available (= !empty)
//  out_ready       in   1                 MAC consumes head this cycle
//  mor_out         out  2*OP_W            head pair {second_operand, first_operand}
//  out_acc_clr     out  1                 tag of head entry
//  count           out  $clog2(DEPTH+1)   occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Reset is asynchronous and active-high, on clock `clock`.
//    On reset: wr_ptr = rd_ptr = count = 0, so out_valid = 0 and in_ready = 1.
//    mor_out and out_acc_clr read 0. Storage array is not reset.
//  - push = in_valid & in_ready. pop = out_valid & out_ready. Both take effect on the rising edge.
//  - in_ready depends only on registered state (count != DEPTH). It has no combinational
//    path from out_ready, so a pop cannot make room for a same-cycle push when full.
//  - Entry = {in_acc_clr, second_operand, first_operand}, i.e. 2*OP_W+1 bits.
//    Written at wr_ptr on push.
//  - mor_out and out_acc_clr come from the entry at rd_ptr while count != 0. They are forced to 0 when empty.
//  - Latency: a pair pushed at edge N is visible on mor_out (out_valid = 1) after edge N.
//    There is no same-cycle bypass when empty.
//  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//  - count next value: +1 on push only; -1 on pop only; unchanged on push & pop together
//    (legal whenever 0 < count < DEPTH).
//  - Full (count == DEPTH): in_ready = 0. in_valid is ignored, no overwrite.
//  - Empty (count == 0): out_valid = 0. out_ready is ignored, no underflow.
//  - flush = 1 at an edge: pointers and count go to 0. Any push or pop in that cycle is discarded.
//  - Reset asserted mid-transfer drops all entries immediately (asynchronous).
//    The first push after reset release lands in entry 0.
//  - The head entry does not change while out_valid = 1 and out_ready = 0 (stable under stall).
// TESTING
//  1. Reset: assert reset mid-burst with count = 3
//     -> count = 0, out_valid = 0, in_ready = 1, mor_out = 0 with no clock edge.
//  2. Single push: first = 32'h1111_1111, second = 32'h2222_2222, acc_clr = 1
//     -> next cycle mor_out = 64'h2222_2222_1111_1111, out_acc_clr = 1, count = 1.
//  3. Fill: push 5 pairs A..E with out_ready = 0
//     -> in_ready drops after the 4th push, E is not stored, count = 4.
//     Then drain -> A, B, C, D in order, count reaches 0.
//  4. Wrap: 10 push/pop pairs at count = 2 with in_valid = out_ready = 1
//     -> count stays 2, outputs appear in FIFO order across pointer wrap.
//  5. Flush: count = 3 with push and pop asserted, flush = 1
//     -> count = 0, out_valid = 0, the pushed pair does not appear later.
//  6. Stall: hold out_ready = 0 for 5 cycles with out_valid = 1
//     -> mor_out and out_acc_clr remain constant.

Source files
------------

// File: rtl/mac_operand_fifo.sv
// mac_operand_fifo
//   Operand staging queue placed in front of the MAC datapath. Each entry holds
//   one {second_operand, first_operand} pair and an accumulator-clear tag. The
//   oldest entry is presented in first-word-fall-through order. The queue lets
//   operand fetch keep running while the MAC is stalled.
//
// Parameters
//   OP_W   width of each operand (mor_out is 2*OP_W wide)
//   DEPTH  number of queue entries; must be a power of two, >= 2
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous, active-high; empties the queue
//   flush           synchronous discard of all entries
//   in_valid        producer offers an operand pair
//   in_ready        queue can accept a pair (not full)
//   first_operand   low half of the pushed pair
//   second_operand  high half of the pushed pair
//   in_acc_clr      pushed pair starts a new accumulation
//   out_valid       head entry is available (not empty)
//   out_ready       MAC consumes the head entry this cycle
//   mor_out         head pair {second_operand, first_operand}; 0 when empty
//   out_acc_clr     tag of the head entry; 0 when empty
//   count           number of occupied entries, 0..DEPTH
module mac_operand_fifo #(
  parameter int OP_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            first_operand,
  input  logic [OP_W-1:0]            second_operand,
  input  logic                       in_acc_clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*OP_W-1:0]          mor_out,
  output logic                       out_acc_clr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = 2*OP_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               pop;

  // Both handshake flags come from registered count only, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is masked to zero while empty so stale storage never leaks out.
  assign head        = mem[rd_ptr];
  assign mor_out     = out_valid ? head[2*OP_W-1:0] : '0;
  assign out_acc_clr = out_valid & head[2*OP_W];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; the empty mask on the outputs covers it.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= {in_acc_clr, second_operand, first_operand};
    end
  end

endmodule
